flit_injector: RTL
==================

Name: flit_injector

Overview:
- Local injection port of the deflection router node; the transmit-side counterpart of the 2x2 steering arbiter.
- Buffers flits from the local core in a small FIFO.
- Each cycle it inspects the two incoming link slots and places the head flit into the first empty slot (slot 1 preferred).
- Its registered outputs feed the arbiter inputs.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- ADDR_W, 2, log2(DEPTH).
- STARVE_LIMIT, 15, saturation value of the starvation counter (fits in 4 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  core presents a flit.
- in_dest  input  3  destination code, becomes flit[8:6].
- in_data  input  6  payload, becomes flit[5:0].
- in_ready  output  1  FIFO can accept; equals not-full.
- link_in1  input  10  incoming slot 1 flit; bit 9 = valid.
- link_in2  input  10  incoming slot 2 flit; bit 9 = valid.
- link_out1  output  10  registered slot 1 toward the arbiter inp1.
- link_out2  output  10  registered slot 2 toward the arbiter inp2.
- fifo_count  output  ADDR_W+1  current occupancy.
- starved  output  1  high while the starvation counter equals STARVE_LIMIT.

Behaviour:
- Flit format: [9] valid, [8:6] destination, [5:0] payload. Injected flit = {1'b1, head_dest, head_data}.
- Reset (async, immediate):
  - link_out1 = 0, link_out2 = 0.
  - FIFO empty, read and write pointers 0, fifo_count = 0.
  - Starvation counter = 0, starved = 0.
  - in_ready = 1 after reset.
- Push: occurs on the edge when in_valid && in_ready. The entry is {in_dest, in_data}, written at the write pointer. The write pointer increments and wraps at DEPTH.
- in_ready is combinational !full. It does not look ahead to a pop in the same cycle, so a full FIFO refuses the push even if a pop happens that cycle.
- Slot selection, evaluated combinationally from link_in1, link_in2 and FIFO state, then registered:
  - FIFO non-empty and link_in1[9]==0: link_out1 <= injected flit, link_out2 <= link_in2. Pop.
  - Else if FIFO non-empty and link_in2[9]==0: link_out1 <= link_in1, link_out2 <= injected flit. Pop.
  - Otherwise: link_out1 <= link_in1, link_out2 <= link_in2. No pop.
- Slot 1 is preferred when both slots are empty.
- At most one injection per cycle.
- Latency: link_in to link_out is exactly 1 cycle, always, whether or not a flit is injected.
- No bypass: a flit pushed on edge N can be injected at the earliest on edge N+1. It appears on link_out at N+1.
- Pop: the read pointer increments and wraps at DEPTH.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
- Full = (count == DEPTH); empty = (count == 0).
- Empty slots that pass through keep their full 10 bits unchanged, including garbage in bits 8:0 when bit 9 is 0. The block never modifies an incoming valid flit.
- Starvation counter, 4 bits:
  - Cleared on any cycle with an injection.
  - Cleared when the FIFO is empty.
  - Otherwise it increments when the FIFO is non-empty and both link_in valid bits are 1.
  - It saturates at STARVE_LIMIT.
  - starved = (counter == STARVE_LIMIT) and is registered with the counter.
- Reset mid-operation: all buffered flits are discarded. The outputs go to 0 asynchronously, without waiting for a clock edge.

Test Plan:
- Reset, then FIFO empty, link_in1=10'h2A5, link_in2=10'h000 -> next cycle link_out1=10'h2A5, link_out2=10'h000, in_ready=1, fifo_count=0.
- Push dest=3'b010, data=6'h15 at edge N, both slots empty -> at edge N+1 link_out1=10'h295, link_out2=link_in2, fifo_count returns to 0.
- FIFO holds one flit, link_in1=10'h3FF, link_in2=10'h07C -> link_out1=10'h3FF and link_out2 = the injected flit with bit 9=1.
- Push 4 flits with both slots always valid -> fifo_count=4, in_ready=0, a fifth in_valid is not accepted; after 15 blocked cycles starved=1; then free slot 1 -> flit 0 is injected and starved drops to 0 the next cycle.
- Steady push every cycle with slot 1 always free -> FIFO order preserved through a pointer wrap (8 flits, payloads 0..7 appear in order); fifo_count holds constant during simultaneous push and pop.
- Assert rst mid-stream with fifo_count=3 -> outputs 0 immediately, fifo_count=0; after release no stale flit is ever injected.

Source files
------------

// File: rtl/flit_injector.sv
// Local injection port of a deflection router node: buffers core flits in a
// small FIFO and drops the head flit into the first empty incoming link slot.
module flit_injector #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_dest,
  input  logic [5:0]        in_data,
  output logic              in_ready,
  input  logic [9:0]        link_in1,
  input  logic [9:0]        link_in2,
  output logic [9:0]        link_out1,
  output logic [9:0]        link_out2,
  output logic [ADDR_W:0]   fifo_count,
  output logic              starved
);

  localparam int unsigned FLIT_W  = 10;
  localparam int unsigned ENTRY_W = 9;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned STV_W   = 4;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [STV_W-1:0]   stv_cnt;
  logic [STV_W-1:0]   stv_next;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [FLIT_W-1:0]  inject_flit;
  logic [FLIT_W-1:0]  out1_next;
  logic [FLIT_W-1:0]  out2_next;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == CNT_W'(0));
  assign in_ready    = !full;
  assign push        = in_valid && !full;
  assign inject_flit = {1'b1, mem[rd_ptr]};
  assign fifo_count  = count;

  // Slot selection: slot 1 preferred, incoming valid flits never touched
  always_comb begin
    pop       = 1'b0;
    out1_next = link_in1;
    out2_next = link_in2;
    if (!empty) begin
      if (!link_in1[9]) begin
        out1_next = inject_flit;
        pop       = 1'b1;
      end else if (!link_in2[9]) begin
        out2_next = inject_flit;
        pop       = 1'b1;
      end
    end
  end

  // Starvation counter: saturating count of cycles blocked by two busy slots
  always_comb begin
    stv_next = stv_cnt;
    if (pop || empty) begin
      stv_next = STV_W'(0);
    end else if (link_in1[9] && link_in2[9] && (stv_cnt != STV_W'(STARVE_LIMIT))) begin
      stv_next = stv_cnt + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_dest, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stv_cnt   <= '0;
      starved   <= 1'b0;
      link_out1 <= '0;
      link_out2 <= '0;
    end else begin
      link_out1 <= out1_next;
      link_out2 <= out2_next;
      stv_cnt   <= stv_next;
      starved   <= (stv_next == STV_W'(STARVE_LIMIT));
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
